perf_counter_bank: RTL and testbench



---
 rtl/perf_cnt_pkg.sv | 13 +
 rtl/perf_cnt_channel.sv | 43 ++++
 rtl/perf_counter_bank.sv | 106 ++++++++++
 tb/tb_perf_counter_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_cnt_pkg.sv
// perf_cnt_pkg: shared constants and types for the performance counter bank
package perf_cnt_pkg;
    localparam logic PERF_MODE_WRAP = 1'b0;
    localparam logic PERF_MODE_SAT  = 1'b1;
    localparam int PERF_NUM_CH_DEF = 8;
    localparam int PERF_WIDTH_DEF  = 32;
    localparam int PERF_STEP_W_DEF = 2;
    // Read response grouping; the data field lives beside it because its width is a bank parameter.
    typedef struct packed {
        logic valid;
        logic ovf;
    } perf_rd_stat_t;
endpackage

// File: rtl/perf_cnt_channel.sv
// perf_cnt_channel: one event counter with wrap/saturate add, clear priority and sticky overflow
//   clk, rst_n : clock, async active-low reset
//   add_en, amt: increment enable and amount
//   clear      : synchronous clear, wins over add_en
//   mode       : PERF_MODE_WRAP / PERF_MODE_SAT
//   cnt, ovf   : counter value and sticky overflow flag
module perf_cnt_channel
    import perf_cnt_pkg::*;
#(
    parameter int WIDTH  = PERF_WIDTH_DEF,
    parameter int STEP_W = PERF_STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_en,
    input  logic [STEP_W-1:0] amt,
    input  logic              clear,
    input  logic              mode,
    output logic [WIDTH-1:0]  cnt,
    output logic              ovf
);
    logic [STEP_W-1:0] a;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  nxt;

    assign a   = add_en ? amt : '0;
    assign sum = {1'b0, cnt} + (WIDTH+1)'(a);
    // The carry bit doubles as the overflow event; a zero add can never produce it.
    assign nxt = (sum[WIDTH] && mode == PERF_MODE_SAT) ? '1 : sum[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= nxt;
            ovf <= ovf | sum[WIDTH];
        end
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with a registered read / read-and-clear port
//   clk, rst_n        : clock, async active-low reset
//   inc, inc_amt      : per-channel strobe and packed increment amounts
//   freeze            : suppresses all increments (not clears or reads)
//   clr, sat_mode     : per-channel clear and saturate(1)/wrap(0) select
//   rd_en/rd_clr/rd_sel -> rd_valid/rd_data/rd_ovf one cycle later
//   ovf               : live sticky overflow flags
//   snap              : only with PERF_CNT_SNAPSHOT_EN; copies all channels into a shadow that reads return
module perf_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter int NUM_CH = PERF_NUM_CH_DEF,
    parameter int WIDTH  = PERF_WIDTH_DEF,
    parameter int STEP_W = PERF_STEP_W_DEF,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        inc,
    input  logic [NUM_CH*STEP_W-1:0] inc_amt,
    input  logic                     freeze,
    input  logic [NUM_CH-1:0]        clr,
    input  logic [NUM_CH-1:0]        sat_mode,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [SEL_W-1:0]         rd_sel,
`ifdef PERF_CNT_SNAPSHOT_EN
    input  logic                     snap,
`endif
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_ovf,
    output logic [NUM_CH-1:0]        ovf
);
    logic [WIDTH-1:0]  cnt     [NUM_CH];
    logic [WIDTH-1:0]  src_cnt [NUM_CH];
    logic [NUM_CH-1:0] live_ovf;
    logic [NUM_CH-1:0] src_ovf;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_ovf;
    perf_rd_stat_t     stat_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_cnt_channel #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .add_en (inc[i] && !freeze),
            .amt    (inc_amt[i*STEP_W +: STEP_W]),
            .clear  (clr[i] || (rd_en && rd_clr && rd_sel == SEL_W'(i))),
            .mode   (sat_mode[i]),
            .cnt    (cnt[i]),
            .ovf    (live_ovf[i])
        );
    end

    assign ovf = live_ovf;

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0]  shd     [NUM_CH];
    logic [NUM_CH-1:0] shd_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd     <= '{default: '0};
            shd_ovf <= '0;
        end else if (snap) begin
            shd     <= cnt;
            shd_ovf <= live_ovf;
        end
    end

    assign src_cnt = shd;
    assign src_ovf = shd_ovf;
`else
    assign src_cnt = cnt;
    assign src_ovf = live_ovf;
`endif

    // Out-of-range selects match no channel and fall through to zero.
    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                sel_data = src_cnt[k];
                sel_ovf  = src_ovf[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q  <= '0;
            rd_data <= '0;
        end else begin
            stat_q.valid <= rd_en;
            if (rd_en) begin
                stat_q.ovf <= sel_ovf;
                rd_data    <= sel_data;
            end
        end
    end

    assign rd_valid = stat_q.valid;
    assign rd_ovf   = stat_q.ovf;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: scoreboard bench for perf_counter_bank
module tb_perf_counter_bank;
    import perf_cnt_pkg::*;
    localparam int NC   = 5;
    localparam int W    = 8;
    localparam int SW   = 2;
    localparam int SELW = 3;
    localparam int MAXV = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NC-1:0]    inc = '0, clr = '0, sat_mode = '0;
    logic [NC*SW-1:0] inc_amt = '0;
    logic             freeze = 1'b0, rd_en = 1'b0, rd_clr = 1'b0, snap = 1'b0;
    logic [SELW-1:0]  rd_sel = '0;
    logic             rd_valid, rd_ovf;
    logic [W-1:0]     rd_data;
    logic [NC-1:0]    ovf;

    perf_counter_bank #(.NUM_CH(NC), .WIDTH(W), .STEP_W(SW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc),
        .inc_amt  (inc_amt),
        .freeze   (freeze),
        .clr      (clr),
        .sat_mode (sat_mode),
        .rd_en    (rd_en),
        .rd_clr   (rd_clr),
        .rd_sel   (rd_sel),
`ifdef PERF_CNT_SNAPSHOT_EN
        .snap     (snap),
`endif
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ovf   (rd_ovf),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ovf;
    } rsp_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   m_cnt [NC];
    bit   m_ovf [NC];
    int   m_shd [NC];
    bit   m_shd_ovf [NC];
    rsp_t exp_q [$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] mvec();
        logic [NC-1:0] v;
        for (int i = 0; i < NC; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_shd[i] = 0; m_shd_ovf[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic step(input logic [NC-1:0] i_inc, input logic [NC*SW-1:0] i_amt,
                        input logic [NC-1:0] i_clr, input logic i_frz, input logic i_rd,
                        input logic i_rclr, input logic [SELW-1:0] i_sel, input logic i_snap);
        rsp_t r;
        int   s, a;
        bit   c;
        inc = i_inc; inc_amt = i_amt; clr = i_clr; freeze = i_frz;
        rd_en = i_rd; rd_clr = i_rclr; rd_sel = i_sel; snap = i_snap;
        if (i_rd) begin
            r.data = 0; r.ovf = 0;
            if (int'(i_sel) < NC) begin
`ifdef PERF_CNT_SNAPSHOT_EN
                r.data = m_shd[i_sel]; r.ovf = m_shd_ovf[i_sel];
`else
                r.data = m_cnt[i_sel]; r.ovf = m_ovf[i_sel];
`endif
            end
            exp_q.push_back(r);
        end
`ifdef PERF_CNT_SNAPSHOT_EN
        if (i_snap) for (int i = 0; i < NC; i++) begin
            m_shd[i] = m_cnt[i]; m_shd_ovf[i] = m_ovf[i];
        end
`endif
        for (int i = 0; i < NC; i++) begin
            c = i_clr[i] || (i_rd && i_rclr && int'(i_sel) == i);
            a = (i_inc[i] && !i_frz) ? int'(i_amt[i*SW +: SW]) : 0;
            if (c) begin
                m_cnt[i] = 0; m_ovf[i] = 0;
            end else begin
                s = m_cnt[i] + a;
                if (s > MAXV) begin
                    m_ovf[i] = 1;
                    m_cnt[i] = sat_mode[i] ? MAXV : s - MAXV - 1;
                end else m_cnt[i] = s;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid, i_rd);
        if (rd_valid && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("rd_data", rd_data, r.data);
            chk("rd_ovf", rd_ovf, r.ovf);
        end
        chk("ovf_vec", ovf, mvec());
        inc = '0; clr = '0; rd_en = 1'b0; rd_clr = 1'b0; snap = 1'b0; freeze = 1'b0;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic incr(input int ch, input int amt, input int n);
        logic [NC-1:0]    vi;
        logic [NC*SW-1:0] va;
        vi = '0; va = '0;
        vi[ch] = 1'b1;
        va[ch*SW +: SW] = SW'(amt);
        for (int k = 0; k < n; k++) step(vi, va, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic clear_ch(input int ch);
        logic [NC-1:0] vc;
        vc = '0;
        vc[ch] = 1'b1;
        step('0, '0, vc, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input int sel, input logic rc);
`ifdef PERF_CNT_SNAPSHOT_EN
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
`endif
        step('0, '0, '0, 1'b0, 1'b1, rc, SELW'(sel), 1'b0);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_rovf", rd_ovf, 0);
        chk("rst_ovf", ovf, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        incr(0, 1, 5);
        rd(0, 1'b0);
        chk("ch0_five", rd_data, 5);
        chk("ch0_five_ovf", rd_ovf, 0);
        idle();
        chk("rd_hold", rd_data, 5);

        incr(1, 3, 84);
        incr(1, 2, 1);
        incr(1, 3, 1);
        chk("wrap_ovf1", ovf[1], 1);
        rd(1, 1'b0);
        chk("wrap_val", rd_data, 1);
        chk("wrap_rovf", rd_ovf, 1);

        clear_ch(1);
        chk("clr_ovf1", ovf[1], 0);
        sat_mode[1] = PERF_MODE_SAT;
        incr(1, 3, 84);
        incr(1, 2, 1);
        incr(1, 3, 1);
        rd(1, 1'b0);
        chk("sat_val", rd_data, MAXV);
        chk("sat_rovf", rd_ovf, 1);

        incr(4, 3, 85);
        sat_mode[4] = PERF_MODE_SAT;
        incr(4, 0, 2);
        chk("zero_add_ovf4", ovf[4], 0);
        rd(4, 1'b0);
        chk("zero_add_val", rd_data, MAXV);

        incr(2, 3, 2);
        incr(2, 1, 1);
        step(5'b00100, 10'b00_00_11_00_00, 5'b00100, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rd(2, 1'b0);
        chk("clr_win_val", rd_data, 0);
        chk("clr_win_ovf", ovf[2], 0);

        step('1, '1, '0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        rd(0, 1'b0);
        chk("freeze_ch0", rd_data, 5);

        incr(3, 3, 3);
        step(5'b01000, 10'b00_10_00_00_00, '0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        chk("rdclr_val", rd_data, 9);
        rd(3, 1'b0);
        chk("rdclr_after", rd_data, 0);

        rd(NC, 1'b1);
        chk("oob_valid", rd_valid, 1);
        chk("oob_data", rd_data, 0);
        rd(0, 1'b0);
        rd(4, 1'b0);
        chk("b2b_data", rd_data, MAXV);

        clear_ch(0);
        incr(0, 3, 33);
        incr(0, 1, 1);
        rd(0, 1'b0);
        chk("pre_rst_val", rd_data, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_rovf", rd_ovf, 0);
        chk("arst_ovf", ovf, 0);
        model_reset();
        sat_mode = '0;
        #2 rst_n = 1'b1;
        incr(0, 1, 2);
        rd(0, 1'b0);
        chk("post_rst_val", rd_data, 2);

`ifdef PERF_CNT_SNAPSHOT_EN
        clear_ch(0);
        incr(0, 1, 4);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        incr(0, 1, 3);
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("snap_val", rd_data, 4);
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        chk("snap_rd_same", rd_data, 4);
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        chk("snap_live", rd_data, 7);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
